// File: rtl/line_fill_buffer.sv
// Line fill buffer: fetches one 8-word cache line over an AXI read
// channel as a wrapping burst. The burst starts at the missing (critical)
// word. That word is presented early on CrtWordData with a FirstWord
// pulse. The assembled line is presented on LineData with a Completed
// pulse. Error is sticky for the current fill.
module line_fill_buffer (
  input  logic         Clk,
  input  logic         Rst,
  input  logic         Enable,
  input  logic [31:0]  WordAddress,
  output logic [31:0]  LineAddress,
  output logic         FirstWord,
  output logic [31:0]  CrtWordData,
  output logic         Completed,
  output logic [255:0] LineData,
  output logic         Error,
  output logic [31:0]  ARADDR,
  output logic [7:0]   ARLEN,
  output logic [2:0]   ARSIZE,
  output logic [1:0]   ARBURST,
  output logic         ARVALID,
  input  logic         ARREADY,
  input  logic [31:0]  RDATA,
  input  logic [1:0]   RRESP,
  input  logic         RLAST,
  input  logic         RVALID,
  output logic         RREADY
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ADDR    = 3'd1,
    S_DATA    = 3'd2,
    S_DONE    = 3'd3,
    S_RELEASE = 3'd4
  } state_t;

  state_t         state_q, state_d;

  logic [31:0]    line_addr_q, line_addr_d;
  logic [31:0]    crt_q, crt_d;
  logic [255:0]   line_q, line_d;
  logic           err_q, err_d;
  logic           first_q, first_d;
  logic [2:0]     off_q, off_d;
  logic [2:0]     cnt_q, cnt_d;

  logic           accept;
  logic           beat;
  logic           last_beat;
  logic [2:0]     widx;

  // A new request is only taken from IDLE. A data beat is only taken
  // while RREADY is up, which is exactly the DATA state.
  assign accept    = (state_q == S_IDLE) && Enable;
  assign beat      = (state_q == S_DATA) && RVALID;
  assign last_beat = (cnt_q == 3'd7);
  assign widx      = off_q + cnt_q;

  // State register
  always_ff @(posedge Clk) begin
    if (Rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic. Enable is only looked at in IDLE and RELEASE, so
  // dropping it mid-fill never aborts a burst already on the bus.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (Enable)          state_d = S_ADDR;
      S_ADDR:    if (ARREADY)         state_d = S_DATA;
      S_DATA:    if (beat && last_beat) state_d = S_DONE;
      S_DONE:                         state_d = S_RELEASE;
      S_RELEASE: if (!Enable)         state_d = S_IDLE;
      default:                        state_d = S_IDLE;
    endcase
  end

  // Handshake and completion outputs decoded from the current state
  always_comb begin
    ARVALID   = 1'b0;
    RREADY    = 1'b0;
    Completed = 1'b0;
    case (state_q)
      S_ADDR:  ARVALID   = 1'b1;
      S_DATA:  RREADY    = 1'b1;
      S_DONE:  Completed = 1'b1;
      default: ;
    endcase
  end

  // Datapath next values: latch the request, scatter beats into the line
  // at (offset + count) mod 8, and capture the critical word on beat 0.
  // The burst is always counted to eight beats, even when a beat is bad.
  always_comb begin
    line_addr_d = line_addr_q;
    crt_d       = crt_q;
    line_d      = line_q;
    err_d       = err_q;
    first_d     = 1'b0;
    off_d       = off_q;
    cnt_d       = cnt_q;
    if (accept) begin
      line_addr_d = WordAddress;
      err_d       = 1'b0;
      off_d       = WordAddress[2:0];
      cnt_d       = 3'd0;
    end
    if (beat) begin
      line_d[{widx, 5'd0} +: 32] = RDATA;
      if (cnt_q == 3'd0) begin
        crt_d   = RDATA;
        first_d = 1'b1;
      end
      if ((RRESP != 2'b00) || (RLAST != last_beat)) err_d = 1'b1;
      cnt_d = cnt_q + 3'd1;
    end
  end

  // Datapath registers; reset clears every visible result
  always_ff @(posedge Clk) begin
    if (Rst) begin
      line_addr_q <= '0;
      crt_q       <= '0;
      line_q      <= '0;
      err_q       <= 1'b0;
      first_q     <= 1'b0;
      off_q       <= 3'd0;
      cnt_q       <= 3'd0;
    end else begin
      line_addr_q <= line_addr_d;
      crt_q       <= crt_d;
      line_q      <= line_d;
      err_q       <= err_d;
      first_q     <= first_d;
      off_q       <= off_d;
      cnt_q       <= cnt_d;
    end
  end

  assign LineAddress = line_addr_q;
  assign CrtWordData = crt_q;
  assign LineData    = line_q;
  assign Error       = err_q;
  assign FirstWord   = first_q;
  assign ARADDR      = {line_addr_q[29:0], 2'b00};
  assign ARLEN       = 8'd7;
  assign ARSIZE      = 3'b010;
  assign ARBURST     = 2'b10;

endmodule

// File: doc/line_fill_buffer.md
LINE_FILL_BUFFER -- requirements
Module: line_fill_buffer

Interface
REQ-001 SHALL have reset Rst, synchronous, active-high; clock Clk.
REQ-002 Ports:
  Clk  in  1  clock
  Rst  in  1  sync active-high reset
  Enable  in  1  fill request level from cache control; held until Completed seen
  WordAddress  in  32  missing word address (word granularity)
  LineAddress  out  32  latched WordAddress of current/last fill
  FirstWord  out  1  one-cycle pulse: critical word valid on CrtWordData
  CrtWordData  out  32  critical word, held until next request accepted
  Completed  out  1  one-cycle pulse: full line valid on LineData
  LineData  out  256  8-word line, word i at bits [32i+31:32i]
  Error  out  1  sticky bad response/RLAST flag for current fill
  ARADDR  out  32  {WordAddress[29:0],2'b00} of latched request
  ARLEN  out  8  constant 7
  ARSIZE  out  3  constant 3'b010
  ARBURST  out  2  constant 2'b10 (WRAP)
  ARVALID  out  1  address valid
  ARREADY  in  1  address accepted
  RDATA  in  32  read beat data
  RRESP  in  2  read beat response
  RLAST  in  1  final beat marker
  RVALID  in  1  beat valid
  RREADY  out  1  beat accept

Function
REQ-003 States SHALL be IDLE, ADDR, DATA, DONE, RELEASE.
REQ-004 IDLE: Enable=1 SHALL latch WordAddress into LineAddress, clear Error, start offset=WordAddress[2:0], beat count=0, go ADDR with ARVALID=1 next cycle.
REQ-005 ADDR: ARVALID SHALL stay 1, ARADDR stable, until ARVALID&&ARREADY; then ARVALID=0, RREADY=1, go DATA.
REQ-006 DATA: each RVALID&&RREADY beat SHALL write RDATA to word (offset+count) mod 8 and increment 3-bit count.
REQ-007 Beat 0 SHALL load CrtWordData and assert FirstWord exactly one cycle, the cycle after the handshake.
REQ-008 RRESP!=0 on any beat, RLAST=1 on beat 0..6, or RLAST=0 on beat 7 SHALL set Error; the burst is still counted to 8 beats.
REQ-009 On beat 7 handshake: RREADY=0, go DONE; Completed=1 during DONE only (one cycle), LineData complete and stable.
REQ-010 DONE SHALL always go RELEASE; RELEASE SHALL go IDLE when Enable=0 and never issue a new request while Enable stays 1.
REQ-011 Enable falling during ADDR/DATA SHALL NOT abort: burst finishes, FirstWord/Completed still pulse, RELEASE exits immediately.
REQ-012 FirstWord and Completed SHALL never coincide; FirstWord precedes Completed by at least 7 cycles.
REQ-013 WordAddress changes after latch SHALL be ignored until next IDLE acceptance.
REQ-014 Beats with RVALID outside DATA SHALL be ignored (RREADY=0).
REQ-015 LineData, CrtWordData, LineAddress SHALL hold between fills; only words written by the current burst change.
REQ-016 Minimum fill latency with ARREADY and RVALID tied high: request in IDLE cycle 0 -> ARVALID cycle 1 -> FirstWord cycle 3 -> Completed cycle 10.

Reset
REQ-017 Rst SHALL force state IDLE, ARVALID=0, RREADY=0, FirstWord=0, Completed=0, Error=0, count=0, LineAddress=0, CrtWordData=0, LineData=0.
REQ-018 Rst mid-burst SHALL abandon the fill immediately with REQ-017 values; the interconnect is reset by the same Rst.
REQ-019 Enable high in first post-reset cycle SHALL start a fill normally.

Verification
REQ-020 Aligned fill: WordAddress=0x100, ARREADY/RVALID=1, RDATA=beat index -> ARADDR=0x400, word i=i, CrtWordData=0, Completed cycle 10.
REQ-021 Critical-word wrap: WordAddress=0x105, RDATA=0xA0..0xA7 -> CrtWordData=0xA0, words 5,6,7,0,1,2,3,4 = 0xA0..0xA7.
REQ-022 Backpressure: ARREADY low 3 cycles, RVALID toggling 1/0 -> ARADDR stable, 8 beats captured, single Completed pulse.
REQ-023 Errors: RRESP=2'b10 on beat 3, then separate fill with early RLAST on beat 5 -> Error=1 both, cleared on next accepted request, Completed still pulses.
REQ-024 Hold/release: Enable held 5 cycles after Completed -> no new ARVALID; drop Enable, reassert -> new fill starts.
REQ-025 Reset at beat 4 -> all outputs at reset values next cycle, no Completed; following fill correct.
